rf_checkpoint_monitor: RTL
==========================

Name: rf_checkpoint_monitor

Overview:
- Synthesizable, parametrised successor to the bench-level register checks used for CPU bring-up.
- Snoops the CPU register-file write port and keeps a shadow register file.
- Runs a programmed checkpoint table: wait for a flag register to reach a value, then compare expected register values.
- Reports pass, fail or timeout; usable in simulation and on FPGA (result to LEDs/UART).

Parameters:
- XLEN, 32, data width of registers and expected values.
- NUM_REGS, 32, architectural register count; index width RW = $clog2(NUM_REGS).
- DEPTH, 16, checkpoint table entries; index width IW = $clog2(DEPTH).
- FLAG_REG, 20, register index polled as the progress flag.
- TIMEOUT_CYCLES, 100, cycles allowed from start to completion.

Ports:
- clk, in, 1, the single clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- rf_we, in, 1, snooped register-file write enable.
- rf_wa, in, RW, snooped write address.
- rf_wd, in, XLEN, snooped write data.
- cfg_we, in, 1, table write strobe.
- cfg_idx, in, IW, table entry index.
- cfg_flag, in, XLEN, flag value that gates this entry.
- cfg_reg, in, RW, register index to check.
- cfg_exp, in, XLEN, expected value.
- cfg_count, in, IW+1, number of valid entries; sampled on start.
- start, in, 1, one-cycle pulse that begins a run.
- busy, out, 1, run in progress.
- pass, out, 1, sticky: all entries matched.
- fail, out, 1, sticky: mismatch detected.
- timeout, out, 1, sticky: TIMEOUT_CYCLES elapsed.
- fail_idx, out, IW, index of the failing entry.
- fail_got, out, XLEN, shadow value at the failure.
- fail_exp, out, XLEN, expected value at the failure.
- checks_done, out, IW+1, count of entries that passed.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - All outputs 0; shadow registers 0; timeout counter 0.
  - Table contents retained (not reset).
  - Reset mid-run aborts the run and leaves no flag set.
- Shadow register file:
  - On rf_we with rf_wa != 0, shadow[rf_wa] <= rf_wd.
  - Writes to x0 are ignored; x0 always reads 0.
  - A write becomes visible to comparisons on the following cycle.
- Configuration:
  - cfg_we writes the entry at cfg_idx when not busy.
  - cfg_we while busy is ignored.
- States: IDLE, WAIT_FLAG, CHECK, DONE.
- IDLE:
  - start pulse: latch cfg_count, clear counter, clear outputs, set ptr to 0, go to WAIT_FLAG, busy=1 on the next cycle.
  - If latched count is 0: go to DONE with pass=1 one cycle after start.
- WAIT_FLAG:
  - When shadow[FLAG_REG] == table[ptr].flag, go to CHECK next cycle.
- CHECK:
  - One entry compared per cycle: shadow[table[ptr].reg] vs table[ptr].exp.
  - Mismatch: fail=1, latch fail_idx/fail_got/fail_exp, go to DONE.
  - Match, ptr is the last entry (ptr == count-1): pass=1, go to DONE.
  - Match, next entry has the same flag: ptr++, stay in CHECK.
  - Match, next entry has a different flag: ptr++, go to WAIT_FLAG.
  - checks_done increments on every match.
- Timeout:
  - Counter increments each cycle in WAIT_FLAG or CHECK.
  - When it reaches TIMEOUT_CYCLES: timeout=1, go to DONE.
  - A pass or fail decided in the same cycle wins over timeout.
- DONE:
  - busy=0; result flags and fail_* hold.
  - A new start clears them and begins a new run.
  - start while busy is ignored.
- Flag compare is exact XLEN equality; the flag value is not required to be monotonic.

Optional Feature:
- Macro RFCHK_MASK_EN.
- Defined:
  - Adds input cfg_mask (XLEN), stored per entry.
  - CHECK compares (shadow & mask) == (exp & mask).
  - fail_got/fail_exp report unmasked values.
- Undefined:
  - No cfg_mask port and no mask storage.
  - Full-width equality compare.

Test Plan:
- Load 4 entries: {flag1,x1,300}, {flag2,x1,500}, {flag2,x2,100}, {flag3,x1,11}. Drive writes x1=300, x20=1, x1=500, x2=100, x20=2, x1=11, x20=3 → pass=1, checks_done=4, fail=0, timeout=0.
- Same table, drive x2=99 instead of 100 → fail=1, fail_idx=2, fail_got=99, fail_exp=100, checks_done=2.
- Same table, never write x20=3, TIMEOUT_CYCLES=100 → timeout=1 exactly 100 cycles after busy rises, pass=0.
- Write x0=5 and entry {flag0,x0,0}, with x20 never written (reads 0) → pass=1.
- cfg_count=0, then start → pass=1 one cycle later; cfg_we during a run leaves the table unchanged (verified by a rerun).
- Assert rst mid-WAIT_FLAG → all outputs 0 immediately; a subsequent start runs correctly. With RFCHK_MASK_EN, mask 0xFF, exp 0x12C, x1=0xF2C → pass.

Source files
------------

// File: rtl/rf_checkpoint_monitor.sv
// Shadows the CPU register-file write port and walks a checkpoint table: wait for a flag value, then compare registers.
// Optional per-entry compare masks are enabled by defining RFCHK_MASK_EN.
module rf_checkpoint_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int DEPTH          = 16,
  parameter int FLAG_REG       = 20,
  parameter int TIMEOUT_CYCLES = 100,
  localparam int RW = $clog2(NUM_REGS),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rf_we,
  input  logic [RW-1:0]   rf_wa,
  input  logic [XLEN-1:0] rf_wd,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [XLEN-1:0] cfg_flag,
  input  logic [RW-1:0]   cfg_reg,
  input  logic [XLEN-1:0] cfg_exp,
`ifdef RFCHK_MASK_EN
  input  logic [XLEN-1:0] cfg_mask,
`endif
  input  logic [IW:0]     cfg_count,
  input  logic            start,
  output logic            busy,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [IW-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_got,
  output logic [XLEN-1:0] fail_exp,
  output logic [IW:0]     checks_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_FLAG = 2'd1;
  localparam logic [1:0] CHECK     = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;
  localparam logic [RW-1:0] FLAG_IDX = RW'(FLAG_REG);

  logic [1:0]      state;
  logic [IW-1:0]   ptr;
  logic [IW:0]     count;
  logic [TW-1:0]   tmo_cnt;

  logic [XLEN-1:0] shadow   [NUM_REGS];
  logic [XLEN-1:0] tbl_flag [DEPTH];
  logic [RW-1:0]   tbl_reg  [DEPTH];
  logic [XLEN-1:0] tbl_exp  [DEPTH];
`ifdef RFCHK_MASK_EN
  logic [XLEN-1:0] tbl_mask [DEPTH];
`endif

  logic [IW-1:0]   ptr_nxt;
  logic [TW-1:0]   tmo_nxt;
  logic [XLEN-1:0] cur_got;
  logic [XLEN-1:0] cur_exp;
  logic [XLEN-1:0] cur_mask;
  logic            flag_hit;
  logic            entry_ok;
  logic            is_last;
  logic            same_flag;
  logic            tmo_hit;

  function automatic logic masked_eq(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                     input logic [XLEN-1:0] m);
    return ((a ^ b) & m) == '0;
  endfunction

  // x0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (rf_we && (rf_wa != '0)) begin
      shadow[rf_wa] <= rf_wd;
    end
  end

  // Table contents survive reset so a board can rerun without reloading.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      tbl_flag[cfg_idx] <= cfg_flag;
      tbl_reg[cfg_idx]  <= cfg_reg;
      tbl_exp[cfg_idx]  <= cfg_exp;
`ifdef RFCHK_MASK_EN
      tbl_mask[cfg_idx] <= cfg_mask;
`endif
    end
  end

  assign busy      = (state == WAIT_FLAG) || (state == CHECK);
  assign ptr_nxt   = ptr + IW'(1);
  assign tmo_nxt   = tmo_cnt + TW'(1);
  assign tmo_hit   = (tmo_nxt == TW'(TIMEOUT_CYCLES));
  assign is_last   = (({1'b0, ptr} + (IW+1)'(1)) == count);
  assign same_flag = (tbl_flag[ptr_nxt] == tbl_flag[ptr]);
  assign flag_hit  = (shadow[FLAG_IDX] == tbl_flag[ptr]);
  assign cur_got   = shadow[tbl_reg[ptr]];
  assign cur_exp   = tbl_exp[ptr];
`ifdef RFCHK_MASK_EN
  assign cur_mask  = tbl_mask[ptr];
`else
  assign cur_mask  = '1;
`endif
  assign entry_ok  = masked_eq(cur_got, cur_exp, cur_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      count       <= '0;
      tmo_cnt     <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_idx    <= '0;
      fail_got    <= '0;
      fail_exp    <= '0;
      checks_done <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count       <= cfg_count;
            ptr         <= '0;
            tmo_cnt     <= '0;
            pass        <= (cfg_count == '0);
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_idx    <= '0;
            fail_got    <= '0;
            fail_exp    <= '0;
            checks_done <= '0;
            state       <= (cfg_count == '0) ? DONE : WAIT_FLAG;
          end
        end
        WAIT_FLAG: begin
          tmo_cnt <= tmo_nxt;
          if (tmo_hit) begin
            timeout <= 1'b1;
            state   <= DONE;
          end else if (flag_hit) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          tmo_cnt <= tmo_nxt;
          // A pass or fail decided this cycle takes priority over the timeout.
          if (!entry_ok) begin
            fail     <= 1'b1;
            fail_idx <= ptr;
            fail_got <= cur_got;
            fail_exp <= cur_exp;
            state    <= DONE;
          end else begin
            checks_done <= checks_done + (IW+1)'(1);
            if (is_last) begin
              pass  <= 1'b1;
              state <= DONE;
            end else if (tmo_hit) begin
              timeout <= 1'b1;
              state   <= DONE;
            end else begin
              ptr   <= ptr_nxt;
              state <= same_flag ? CHECK : WAIT_FLAG;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
